// File: rtl/uram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// uram_stream_reader_if
//
// Purpose: valid/ready word stream with an end-of-job marker, as produced by
// uram_stream_reader and consumed by any downstream block.
//
// Signals:
//   valid  word available (driven by master)
//   ready  consumer accepts the word this cycle (driven by slave)
//   data   DATA_WIDTH stream word (driven by master)
//   last   final word of the job, qualified by valid (driven by master)
// ---------------------------------------------------------------------------
interface uram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/uram_stream_reader.sv
// ---------------------------------------------------------------------------
// uram_stream_reader
//
// Purpose: read-side master for the dual-port URAM. Accepts a (base, length)
// job, issues one read per cycle on RAM port B while capture-FIFO credit is
// available, and replays the returned words as a valid/ready stream with a
// last flag. The RAM read path cannot stall, so issue is throttled by credit
// instead of by downstream ready.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   start          job request, sampled only while idle
//   base_addr      first word address of the job
//   length         words to read (0 = empty job, done pulse only)
//   busy           job in progress
//   done           one-cycle pulse at job completion
//   rd_addr_vld    read strobe to RAM port B
//   rd_addr        read address to RAM port B
//   rd_data_vld    read data valid from RAM (RD_LATENCY after rd_addr_vld)
//   rd_data        read data from RAM
//   m              output stream (valid/ready/data/last), master side
// ---------------------------------------------------------------------------
module uram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_addr_vld,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_data_vld,
    input  logic [DATA_WIDTH-1:0] rd_data,
    uram_stream_reader_if.master  m
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IGN_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W:0] DEPTH_U = FIFO_DEPTH[CNT_W:0];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH:0]     remaining;
    logic [ADDR_WIDTH:0]     job_len;
    logic [ADDR_WIDTH:0]     out_cnt;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [IGN_W-1:0]        ign_cnt;

    logic [CNT_W:0]          used;
    logic                    has_credit;
    logic                    issue;
    logic                    rd_accept;
    logic                    fifo_pop;

    // Every issued read owns a FIFO slot until its word is popped, so the
    // FIFO can never be written while full.
    assign used        = {1'b0, fifo_count} + {1'b0, inflight};
    assign has_credit  = (used < DEPTH_U);
    assign issue       = (state == ISSUE) && has_credit;
    assign rd_addr_vld = issue;
    assign rd_addr     = cur_addr;
    assign busy        = (state != IDLE);

    // The RAM valid pipeline is not reset; returns during the ignore window
    // belong to reads from before reset and are dropped.
    assign rd_accept   = rd_data_vld && (ign_cnt == '0);

    assign fifo_pop    = m.valid && m.ready;
    assign m.valid     = (fifo_count != '0);
    assign m.data      = m.valid ? mem[rd_ptr] : '0;
    assign m.last      = m.valid && (out_cnt == job_len - 1'b1);

    // Job sequencing: latch the job, walk the address, and finish once the
    // beat flagged last has been taken by the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            job_len   <= '0;
            out_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fifo_pop) begin
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            cur_addr  <= base_addr;
                            remaining <= length;
                            job_len   <= length;
                            out_cnt   <= '0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_pop && m.last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit bookkeeping, FIFO pointers and the post-reset ignore window.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ign_cnt    <= IGN_W'(RD_LATENCY);
        end else begin
            if (ign_cnt != '0) begin
                ign_cnt <= ign_cnt - 1'b1;
            end
            case ({issue, rd_accept})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            case ({rd_accept, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (rd_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; m.data is gated by the entry count.
    always_ff @(posedge clk) begin
        if (!rst && rd_accept) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    // A write into a full FIFO means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rd_accept && ({1'b0, fifo_count} == DEPTH_U)));
        end
    end

endmodule

// File: tb/tb_uram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_uram_stream_reader
//
// Self-checking bench for uram_stream_reader. A fixed-latency RAM model with
// an unreset valid pipeline feeds the DUT; expected addresses and words are
// computed per job from the RAM image and checked beat by beat.
// ---------------------------------------------------------------------------
module tb_uram_stream_reader;

    localparam int DW     = 32;
    localparam int AW     = 14;
    localparam int LAT    = 3;
    localparam int DEPTH  = 8;
    localparam int NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic          rd_addr_vld;
    logic [AW-1:0] rd_addr;
    logic          rd_data_vld;
    logic [DW-1:0] rd_data;

    uram_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0]  ram [NWORDS];
    logic [LAT-1:0] vld_pipe = '0;
    logic [DW-1:0]  dat_pipe [LAT];

    logic [DW-1:0]  exp_q [$];
    logic [AW-1:0]  exp_addr_q [$];

    int   occ, max_occ, addr_cnt;
    int   vld_run, max_vld_run, beat_run, max_beat_run;
    int   first_valid_cyc, last_cyc, done_cyc, done_cnt;
    logic busy_at_done;

    uram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rd_addr_vld(rd_addr_vld),
        .rd_addr    (rd_addr),
        .rd_data_vld(rd_data_vld),
        .rd_data    (rd_data),
        .m          (s_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port B: fixed read latency, valid pipeline without reset.
    always @(posedge clk) begin
        vld_pipe    <= {vld_pipe[LAT-2:0], rd_addr_vld};
        dat_pipe[0] <= ram[rd_addr];
        for (int i = 1; i < LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
    end
    assign rd_data_vld = vld_pipe[LAT-1];
    assign rd_data     = dat_pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor: compares every read address and stream beat to the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_addr_vld) begin
                addr_cnt++;
                occ++;
                vld_run++;
                if (exp_addr_q.size() == 0) checkOutput("unexpected_read", 1, 0);
                else checkOutput("rd_addr", rd_addr, exp_addr_q.pop_front());
            end else begin
                vld_run = 0;
            end
            if (vld_run > max_vld_run) max_vld_run = vld_run;
            if (s_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_if.valid && s_if.ready) begin
                occ--;
                beat_run++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    checkOutput("m_data", s_if.data, exp_q.pop_front());
                    checkOutput("m_last", s_if.last, exp_q.size() == 0);
                    if (s_if.last) last_cyc = cyc;
                end
            end else begin
                beat_run = 0;
            end
            if (beat_run > max_beat_run) max_beat_run = beat_run;
            if (occ > max_occ) max_occ = occ;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic clearMon();
        occ = 0; max_occ = 0; addr_cnt = 0;
        vld_run = 0; max_vld_run = 0; beat_run = 0; max_beat_run = 0;
        first_valid_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
        busy_at_done = 1'b1;
    endtask

    // Pulses start for one cycle; call just after a rising edge. Returns the
    // cycle index right after the sampling edge.
    task automatic applyStimulus(input logic [AW-1:0] base, input int len,
                                 input bit track, output int acc);
        logic [AW-1:0] a;
        start     = 1'b1;
        base_addr = base;
        length    = len[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        acc   = cyc;
        if (track) begin
            for (int i = 0; i < len; i++) begin
                a = base + i[AW-1:0];
                exp_addr_q.push_back(a);
                exp_q.push_back(ram[a]);
            end
        end
    endtask

    // mode 0: ready high, 1: one cycle on / three off, 2: random ready.
    task automatic waitDone(input int mode, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            case (mode)
                1:       s_if.ready = (n % 4 == 0);
                2:       s_if.ready = ($urandom_range(0, 1) != 0);
                default: s_if.ready = 1'b1;
            endcase
        end
        s_if.ready = 1'b1;
        checkOutput({tag, "_done_seen"}, done_cnt != 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic checkJob(input string tag, input int len);
        checkOutput({tag, "_exp_left"}, exp_q.size(), 0);
        checkOutput({tag, "_addr_cnt"}, addr_cnt, len);
        checkOutput({tag, "_done_cnt"}, done_cnt, 1);
        checkOutput({tag, "_done_after_last"}, done_cyc, last_cyc + 1);
        checkOutput({tag, "_busy_at_done"}, busy_at_done, 0);
        checkOutput({tag, "_occ_le_depth"}, max_occ <= DEPTH, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rd_addr_vld"}, rd_addr_vld, 0);
        checkOutput({tag, "_rd_addr"}, rd_addr, 0);
        checkOutput({tag, "_m_valid"}, s_if.valid, 0);
        checkOutput({tag, "_m_last"}, s_if.last, 0);
        checkOutput({tag, "_m_data"}, s_if.data, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int len;
        logic [AW-1:0] base;

        for (int i = 0; i < NWORDS; i++) ram[i] = DW'(i);
        s_if.ready = 1'b1;
        clearMon();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("[TB] basic read");
        clearMon();
        applyStimulus(14'h0010, 5, 1'b1, acc);
        waitDone(0, "basic");
        checkJob("basic", 5);
        checkOutput("basic_first_valid", first_valid_cyc, acc + 1 + LAT);
        checkOutput("basic_addr_run", max_vld_run, 5);
        checkOutput("basic_beat_run", max_beat_run, 5);

        for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;

        $display("[TB] backpressure");
        clearMon();
        base = AW'($urandom_range(0, NWORDS - 1));
        applyStimulus(base, 20, 1'b1, acc);
        waitDone(1, "bp");
        checkJob("bp", 20);

        $display("[TB] address wrap");
        clearMon();
        applyStimulus(14'h3FFE, 4, 1'b1, acc);
        waitDone(0, "wrap");
        checkJob("wrap", 4);
        checkOutput("wrap_first_valid", first_valid_cyc, acc + 1 + LAT);

        $display("[TB] empty job");
        clearMon();
        applyStimulus(AW'($urandom_range(0, NWORDS - 1)), 0, 1'b1, acc);
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("empty_done_cyc", done_cyc, acc);
        checkOutput("empty_done_cnt", done_cnt, 1);
        checkOutput("empty_addr_cnt", addr_cnt, 0);

        $display("[TB] start while busy");
        clearMon();
        base = AW'($urandom_range(0, NWORDS - 1));
        applyStimulus(base, 6, 1'b1, acc);
        @(posedge clk); #1;
        applyStimulus(AW'($urandom_range(0, NWORDS - 1)), $urandom_range(1, 20), 1'b0, acc2);
        waitDone(0, "ign");
        checkJob("ign", 6);
        checkOutput("ign_idle_after", busy, 0);

        $display("[TB] reset mid-job");
        clearMon();
        base = AW'($urandom_range(0, NWORDS - 1));
        applyStimulus(base, 10, 1'b1, acc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        clearMon();
        @(negedge clk);
        checkResetOutputs("midrst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("stale_valid", s_if.valid, 0);
            checkOutput("stale_done", done, 0);
        end
        @(posedge clk); #1;
        base = AW'($urandom_range(0, NWORDS - 1));
        applyStimulus(base, 2, 1'b1, acc);
        waitDone(0, "after_rst");
        checkJob("after_rst", 2);

        $display("[TB] throughput");
        clearMon();
        base = AW'($urandom_range(0, NWORDS - 1));
        applyStimulus(base, 64, 1'b1, acc);
        waitDone(0, "thru");
        checkJob("thru", 64);
        checkOutput("thru_addr_run", max_vld_run, 64);
        checkOutput("thru_beat_run", max_beat_run, 64);

        $display("[TB] random jobs");
        for (int j = 0; j < 4; j++) begin
            clearMon();
            len  = $urandom_range(1, 40);
            base = AW'($urandom_range(0, NWORDS - 1));
            applyStimulus(base, len, 1'b1, acc);
            waitDone(2, "rand");
            checkJob("rand", len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
